// File: rtl/mii_frame_transmitter.sv
// MII egress framer: preamble/SFD, payload, zero pad to minimum length, CRC-32 FCS
// and inter-packet gap, one nibble per TX clock.
module mii_frame_transmitter #(
  parameter int unsigned MIN_FRAME_BYTES  = 60,
  parameter int unsigned IPG_NIBBLES      = 24,
  parameter int unsigned PREAMBLE_NIBBLES = 15
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        mii_tx_en,
  output logic        mii_tx_er,
  output logic [3:0]  mii_tx_data,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] underrun_count
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StPad,
    StFcs,
    StErr,
    StIpg
  } state_e;

  localparam logic [31:0] CrcPoly      = 32'hEDB88320;
  localparam logic [7:0]  PreambleLast = 8'(PREAMBLE_NIBBLES);
  // The IDLE accept cycle is the final gap nibble, so IPG itself lasts one cycle less.
  localparam logic [7:0]  IpgLast      = 8'(IPG_NIBBLES - 2);
  localparam logic [15:0] MinBytes     = 16'(MIN_FRAME_BYTES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic [3:0]  tx_data_q, tx_data_d;
  logic [31:0] fcs_d;
  logic        ready;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    byte_d         = byte_q;
    last_d         = last_q;
    crc_d          = crc_q;
    byte_cnt_d     = byte_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    ready          = 1'b0;

    case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (s_valid) begin
          byte_d     = s_data;
          last_d     = s_last;
          crc_d      = '1;
          byte_cnt_d = '0;
          cnt_d      = '0;
          state_d    = StPreamble;
        end
      end
      StPreamble: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PreambleLast) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          crc_d      = crc_byte(crc_q, byte_q);
          byte_cnt_d = byte_cnt_inc;
          phase_d    = 1'b0;
          if (last_q) begin
            cnt_d   = '0;
            state_d = (byte_cnt_inc < MinBytes) ? StPad : StFcs;
          end else begin
            ready = 1'b1;
            if (s_valid) begin
              byte_d = s_data;
              last_d = s_last;
            end else begin
              state_d = StErr;
            end
          end
        end
      end
      StPad: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          crc_d      = crc_byte(crc_q, 8'h00);
          byte_cnt_d = byte_cnt_inc;
          phase_d    = 1'b0;
          if (byte_cnt_inc >= MinBytes) begin
            cnt_d   = '0;
            state_d = StFcs;
          end
        end
      end
      StFcs: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd7) begin
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StIpg;
        end
      end
      StErr: begin
        cnt_d          = '0;
        underrun_cnt_d = underrun_cnt_q + 16'd1;
        state_d        = StIpg;
      end
      StIpg: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == IpgLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    fcs_d     = ~crc_d;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    tx_data_d = 4'h0;
    case (state_d)
      StPreamble: begin
        tx_en_d   = 1'b1;
        tx_data_d = (cnt_d == PreambleLast) ? 4'hD : 4'h5;
      end
      StData: begin
        tx_en_d   = 1'b1;
        tx_data_d = phase_d ? byte_d[7:4] : byte_d[3:0];
      end
      StPad: tx_en_d = 1'b1;
      StFcs: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_d[{cnt_d[2:0], 2'b00} +: 4];
      end
      StErr: begin
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      phase_q        <= 1'b0;
      byte_q         <= '0;
      last_q         <= 1'b0;
      crc_q          <= '1;
      byte_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
      tx_en_q        <= 1'b0;
      tx_er_q        <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      byte_q         <= byte_d;
      last_q         <= last_d;
      crc_q          <= crc_d;
      byte_cnt_q     <= byte_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
      tx_en_q        <= tx_en_d;
      tx_er_q        <= tx_er_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign s_ready        = rst_n & ready;
  assign busy           = (state_q != StIdle);
  assign mii_tx_en      = tx_en_q;
  assign mii_tx_er      = tx_er_q;
  assign mii_tx_data    = tx_data_q;
  assign frame_count    = frame_cnt_q;
  assign underrun_count = underrun_cnt_q;

endmodule
